serial_sub: RTL

//  Bit-serial N-bit subtractor: the inverse operation to the full-adder datapath.
//  It computes diff = a - b - bin, LSB first, one bit per clock, through one

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_fs.sv | 14 +
 rtl/serial_sub.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Imported by the top and the full-subtractor cell.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Counter width able to hold 0..w.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational full subtractor: d = a ^ b ^ bin with borrow out.
// Mirror image of the full-adder cell.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Operands in and results out over valid/ready handshakes.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LAST = cnt_t'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_nx;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             brw;
    logic             brw_n;
    logic             d_bit;
    cnt_t             count;
    logic             accept;
    logic             last;
    logic             handoff;

    fs_cell u_fs (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (brw),
        .d   (d_bit),
        .bout(brw_n)
    );

    // New bit enters at the MSB so the LSB-first stream ends up in place.
    generate
        if (WIDTH == 1) begin : g_one
            assign diff_nx = d_bit;
        end else begin : g_many
            assign diff_nx = {d_bit, diff_sh[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;

    assign accept  = in_valid && in_ready;
    assign last    = (count == LAST);
    assign handoff = out_valid && out_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept)  state_n = SHIFT;
            SHIFT:   if (last)    state_n = DONE;
            DONE:    if (handoff) state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
            brw     <= 1'b0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_nx;
                    brw     <= brw_n;
                    count   <= count + cnt_t'(1);
                    // Publish the result on the same edge that enters DONE.
                    if (last) begin
                        diff_r <= diff_nx;
                        bout_r <= brw_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
